// File: rtl/local_bus_master_if.sv
// rtl/local_bus_master_if.sv - command/response and ALE/CS/ACK local-bus signal bundle
interface local_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ale;
  logic        cs_n;
  logic        rd_wr;
  logic        ack_n;
  logic [31:0] lb_data;
  logic [31:0] lb_rdata;

  modport master (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata, ack_n, lb_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, ale, cs_n, rd_wr, lb_data
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_addr, cmd_wdata, ack_n, lb_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, ale, cs_n, rd_wr, lb_data
  );
endinterface

// File: rtl/local_bus_master.sv
// rtl/local_bus_master.sv - single-outstanding command to ALE/CS/ACK local-bus cycle master
module local_bus_master #(
  parameter int ALE_CYCLES = 2,
  parameter int ADDR_HOLD  = 2,
  parameter int TO_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  local_bus_master_if.master  bus
);

  localparam int PH_MAX = (ALE_CYCLES > ADDR_HOLD) ? ALE_CYCLES : ADDR_HOLD;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
  localparam logic [PH_W-1:0] ALE_LAST  = PH_W'(ALE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(ADDR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, ALE_HI, ALE_LO, WAIT_ACK, WAIT_REL, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic              to_sat;
  logic              ale_q, ale_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_wr_q, rd_wr_d;
  logic [31:0]       lb_data_q, lb_data_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  assign to_inc = to_q + TO_W'(1);
  assign to_sat = (to_inc == {TO_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      to_q        <= '0;
      ale_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_wr_q     <= 1'b1;
      lb_data_q   <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      to_q        <= to_d;
      ale_q       <= ale_d;
      cs_n_q      <= cs_n_d;
      rd_wr_q     <= rd_wr_d;
      lb_data_q   <= lb_data_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Every bus output is computed here one cycle ahead and registered above.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    to_d        = to_q;
    ale_d       = ale_q;
    cs_n_d      = cs_n_q;
    rd_wr_d     = rd_wr_q;
    lb_data_d   = lb_data_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = ALE_HI;
          ph_d      = '0;
          ale_d     = 1'b1;
          lb_data_d = bus.cmd_addr;
          rd_wr_d   = bus.cmd_rd;
          wdata_d   = bus.cmd_wdata;
          err_d     = 1'b0;
        end
      end

      ALE_HI: begin
        if (ph_q == ALE_LAST) begin
          state_d = ALE_LO;
          ph_d    = '0;
          ale_d   = 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      // Address stays on lb_data here; data and cs_n switch together.
      ALE_LO: begin
        if (ph_q == HOLD_LAST) begin
          state_d   = WAIT_ACK;
          ph_d      = '0;
          lb_data_d = rd_wr_q ? 32'h0 : wdata_q;
          cs_n_d    = 1'b0;
          to_d      = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      WAIT_ACK: begin
        if (!bus.ack_n) begin
          state_d = WAIT_REL;
          cs_n_d  = 1'b1;
          to_d    = '0;
          if (rd_wr_q) begin
            rsp_rdata_d = bus.lb_rdata;
          end
        end else if (to_sat) begin
          state_d = WAIT_REL;
          cs_n_d  = 1'b1;
          to_d    = '0;
          err_d   = 1'b1;
          if (rd_wr_q) begin
            rsp_rdata_d = 32'h0;
          end
        end else begin
          to_d = to_inc;
        end
      end

      // A slave still holding ack_n low at saturation is reported as an error.
      WAIT_REL: begin
        if (bus.ack_n || to_sat) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q | ~bus.ack_n;
          err_d       = err_q | ~bus.ack_n;
          lb_data_d   = 32'h0;
          rd_wr_d     = 1'b1;
          to_d        = '0;
        end else begin
          to_d = to_inc;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ale       = ale_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.rd_wr     = rd_wr_q;
  assign bus.lb_data   = lb_data_q;

endmodule

// File: doc/local_bus_master.md
Name: local_bus_master

Overview:
- Upstream driver for the management local bus. Converts a single-beat command interface (valid/ready) from the management controller into the ALE/CS/ACK local-bus cycle that the UM register slave consumes.
- Per command it runs one address phase and one data phase, then returns a one-cycle response.
- The response carries read data, or an error flag when the slave never acknowledges.
- Exactly one transaction is outstanding at a time.

Parameters:
- ALE_CYCLES, 2: cycles ale is held high during the address phase (min 1).
- ADDR_HOLD, 2: cycles the address stays on lb_data after ale falls, before cs_n asserts (min 1).
- TO_W, 8: timeout counter width. Timeout fires when the counter reaches 2^TO_W-1 cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_rd  in  1  1=read, 0=write.
- cmd_addr  in  32  full address word; [31:28] is the space, 4'b0001 selects UM.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_rdata  out  32  read data, valid while rsp_valid=1.
- rsp_err  out  1  timeout flag, valid while rsp_valid=1.
- ale  out  1  address latch enable.
- cs_n  out  1  chip select, active low.
- rd_wr  out  1  1=read, 0=write.
- ack_n  in  1  slave acknowledge, active low.
- lb_data  out  32  address/write-data bus to the slave.
- lb_rdata  in  32  read-data bus from the slave.

Behaviour:
- Reset values (asynchronous, immediate even mid-transaction):
  - ale=0, cs_n=1, rd_wr=1, lb_data=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State=IDLE, so cmd_ready=1.
  - The timeout counter and phase counter are cleared.
- All bus outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, latch cmd_rd, cmd_addr and cmd_wdata.
  - Next cycle: drive lb_data=addr, rd_wr=cmd_rd, ale=1; go to ALE_HI.
- ALE_HI:
  - Hold ale=1 for ALE_CYCLES cycles, then ale=0; go to ALE_LO.
- ALE_LO:
  - lb_data keeps the address for ADDR_HOLD cycles.
  - Then drive lb_data=wdata (writes) or 0 (reads), set cs_n=0 in the same cycle, clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - cs_n stays 0; lb_data and rd_wr are stable.
  - On ack_n=0: capture lb_rdata into rsp_rdata if rd_wr=1, set cs_n=1; go to WAIT_REL.
  - If the counter saturates first: cs_n=1, error latched; go to WAIT_REL.
- WAIT_REL:
  - Wait for ack_n=1, with the timeout counter restarted.
  - On ack_n=1 or saturation: go to DONE.
  - A saturation here also sets the error flag.
- DONE:
  - One cycle: rsp_valid=1, rsp_err=latched flag.
  - lb_data=0, rd_wr=1; return to IDLE.
  - rsp_rdata holds its value until the next read completes. On a timed-out read it is 0.
- Bus-cycle spacing:
  - ale never overlaps cs_n=0.
  - At least one IDLE cycle separates consecutive transactions.
  - Write latency from accept: 1 + ALE_CYCLES + ADDR_HOLD + (cycles to ack) + (cycles to release) + 1.
- Other boundary rules:
  - cmd_valid while not in IDLE is ignored (cmd_ready=0).
  - ack_n=0 already low on entry to WAIT_ACK is accepted in the first cycle.
  - ack_n glitching low during the address phase is ignored.

Test Plan:
- Write: cmd_addr=0x1000000A, cmd_wdata=0x00000040, cmd_rd=0, with a slave model that acks 4 cycles after cs_n falls → ale high 2 cycles; lb_data=0x1000000A through ale low +2; cs_n low with lb_data=0x40; rsp_valid=1, rsp_err=0.
- Read: cmd_addr=0x10000000, cmd_rd=1, slave returns 0x0132DA40 with ack → rsp_rdata=0x0132DA40, rsp_err=0, rd_wr=1 throughout.
- Timeout: cmd_addr=0x20000000 with a slave that never acks → cs_n=1 after 255 WAIT_ACK cycles; rsp_valid with rsp_err=1, rsp_rdata=0.
- Back-to-back: cmd_valid held high with two commands → second accepted only after rsp_valid plus one cycle; no overlap of ale and cs_n=0.
- Reset mid-WAIT_ACK: reset low while cs_n=0 → cs_n=1, ale=0, cmd_ready=1 immediately; no rsp_valid pulse.
- Late release: slave holds ack_n=0 for 10 cycles after cs_n rises → rsp_valid exactly 1 cycle after ack_n returns high, rsp_err=0.
